// File: rtl/bster_cmd_mux_if.sv
// Command, completion and status streams between the host clients, bster_cmd_mux and the engine.
// slave is the mux view; master is the client/engine environment view.
interface bster_cmd_mux_if #(
    parameter int NB_CHANNEL = 4,
    parameter int CMD_WIDTH  = 128,
    parameter int STS_WIDTH  = 8
);
    logic [NB_CHANNEL-1:0]           s_cmd_tvalid;
    logic [NB_CHANNEL-1:0]           s_cmd_tready;
    logic [NB_CHANNEL*CMD_WIDTH-1:0] s_cmd_tdata;
    logic [NB_CHANNEL-1:0]           s_cpl_tvalid;
    logic [NB_CHANNEL-1:0]           s_cpl_tready;
    logic [NB_CHANNEL*CMD_WIDTH-1:0] s_cpl_tdata;
    logic [NB_CHANNEL-1:0]           s_sts_tvalid;
    logic [NB_CHANNEL-1:0]           s_sts_tready;
    logic [NB_CHANNEL*STS_WIDTH-1:0] s_sts_tdata;
    logic                            m_cmd_tvalid;
    logic                            m_cmd_tready;
    logic [CMD_WIDTH-1:0]            m_cmd_tdata;
    logic                            m_cpl_tvalid;
    logic                            m_cpl_tready;
    logic [CMD_WIDTH-1:0]            m_cpl_tdata;
    logic                            m_sts_tvalid;
    logic                            m_sts_tready;
    logic [STS_WIDTH-1:0]            m_sts_tdata;

    modport slave (
        input  s_cmd_tvalid, s_cmd_tdata, s_cpl_tready, s_sts_tready,
        input  m_cmd_tready, m_cpl_tvalid, m_cpl_tdata, m_sts_tvalid, m_sts_tdata,
        output s_cmd_tready, s_cpl_tvalid, s_cpl_tdata, s_sts_tvalid, s_sts_tdata,
        output m_cmd_tvalid, m_cmd_tdata, m_cpl_tready, m_sts_tready
    );

    modport master (
        output s_cmd_tvalid, s_cmd_tdata, s_cpl_tready, s_sts_tready,
        output m_cmd_tready, m_cpl_tvalid, m_cpl_tdata, m_sts_tvalid, m_sts_tdata,
        input  s_cmd_tready, s_cpl_tvalid, s_cpl_tdata, s_sts_tvalid, s_sts_tdata,
        input  m_cmd_tvalid, m_cmd_tdata, m_cpl_tready, m_sts_tready
    );
endinterface

// File: rtl/bster_cmd_mux.sv
// Multi-channel command front end for the bster engine: arbitrates client commands, tags them in order
// and routes completion/status beats back. Define BSTER_CMD_MUX_PRIO_EN for fixed-priority arbitration.
module bster_cmd_mux #(
    parameter int NB_CHANNEL = 4,
    parameter int CMD_WIDTH  = 128,
    parameter int STS_WIDTH  = 8,
    parameter int TAG_DEPTH  = 8
) (
    input  logic           aclk,
    input  logic           areset,
    bster_cmd_mux_if.slave bus,
    output logic           busy
);
    localparam int CH_W  = $clog2(NB_CHANNEL);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [CH_W-1:0]  ch_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam logic [NB_CHANNEL-1:0] ONE_CH = {{(NB_CHANNEL-1){1'b0}}, 1'b1};

    logic                 cmd_valid_q, cmd_valid_d;
    logic [CMD_WIDTH-1:0] cmd_data_q,  cmd_data_d;
    ptr_t                 wr_ptr_q,    wr_ptr_d;
    ptr_t                 rd_ptr_q,    rd_ptr_d;
    cnt_t                 count_q,     count_d;
    logic                 cpl_done_q,  cpl_done_d;
    logic                 sts_done_q,  sts_done_d;
    ch_t                  tag_mem_q [TAG_DEPTH];

    logic grant_vld;
    ch_t  grant_idx;
    ch_t  head;
    logic empty, full, load_en, accept_ok, push, pop;
    logic cpl_open, sts_open, cpl_route, sts_route, cpl_fire, sts_fire;

`ifdef BSTER_CMD_MUX_PRIO_EN
    // Descending scan so the lowest requesting index is the last to write, and wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = NB_CHANNEL - 1; i >= 0; i--) begin
            if (bus.s_cmd_tvalid[i]) begin
                grant_vld = 1'b1;
                grant_idx = ch_t'(i);
            end
        end
    end
`else
    ch_t rr_ptr_q, rr_ptr_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NB_CHANNEL; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NB_CHANNEL) idx = idx - NB_CHANNEL;
            if (!grant_vld && bus.s_cmd_tvalid[idx]) begin
                grant_vld = 1'b1;
                grant_idx = ch_t'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) rr_ptr_d = ch_t'((int'(grant_idx) + 1) % NB_CHANNEL);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign head  = tag_mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == cnt_t'(TAG_DEPTH));

    assign cpl_open  = !empty && !cpl_done_q;
    assign sts_open  = !empty && !sts_done_q;
    assign cpl_route = cpl_open && bus.m_cpl_tvalid;
    assign sts_route = sts_open && bus.m_sts_tvalid;
    assign cpl_fire  = cpl_route && bus.s_cpl_tready[head];
    assign sts_fire  = sts_route && bus.s_sts_tready[head];
    assign pop       = !empty && (cpl_done_q || cpl_fire) && (sts_done_q || sts_fire);

    // A full FIFO still accepts when the head retires in the same cycle.
    assign load_en   = !cmd_valid_q || bus.m_cmd_tready;
    assign accept_ok = !areset && load_en && (!full || pop);
    assign push      = accept_ok && grant_vld;

    assign bus.s_cmd_tready = push ? (ONE_CH << grant_idx) : '0;
    assign bus.m_cmd_tvalid = cmd_valid_q;
    assign bus.m_cmd_tdata  = cmd_data_q;

    assign bus.s_cpl_tvalid = cpl_route ? (ONE_CH << head) : '0;
    assign bus.s_cpl_tdata  = {NB_CHANNEL{bus.m_cpl_tdata}};
    assign bus.m_cpl_tready = cpl_open && bus.s_cpl_tready[head];

    assign bus.s_sts_tvalid = sts_route ? (ONE_CH << head) : '0;
    assign bus.s_sts_tdata  = {NB_CHANNEL{bus.m_sts_tdata}};
    assign bus.m_sts_tready = sts_open && bus.s_sts_tready[head];

    assign busy = cmd_valid_q || !empty;

    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_data_d  = cmd_data_q;
        if (load_en) begin
            cmd_valid_d = push;
            if (push) cmd_data_d = bus.s_cmd_tdata[grant_idx*CMD_WIDTH +: CMD_WIDTH];
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (push && !pop)      count_d = count_q + cnt_t'(1);
        else if (!push && pop) count_d = count_q - cnt_t'(1);

        cpl_done_d = pop ? 1'b0 : (cpl_done_q || cpl_fire);
        sts_done_d = pop ? 1'b0 : (sts_done_q || sts_fire);
    end

    // NOTE: flops update with <= so every register samples the values from before the edge.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cpl_done_q  <= 1'b0;
            sts_done_q  <= 1'b0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cpl_done_q  <= cpl_done_d;
            sts_done_q  <= sts_done_d;
        end
    end

    // NOTE: tag storage is not reset; an entry is only read after count_q shows it was written.
    always_ff @(posedge aclk) begin
        if (push) tag_mem_q[wr_ptr_q] <= grant_idx;
    end
endmodule

// File: tb/tb_bster_cmd_mux.sv
// Directed self-checking bench for bster_cmd_mux: arbitration, stall, full FIFO, return routing, reset.
module tb_bster_cmd_mux;
    localparam int NB = 4;
    localparam int CW = 128;
    localparam int SW = 8;
    localparam int TD = 8;

    logic aclk = 1'b0;
    logic areset;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    bster_cmd_mux_if #(.NB_CHANNEL(NB), .CMD_WIDTH(CW), .STS_WIDTH(SW)) bus ();

    bster_cmd_mux #(
        .NB_CHANNEL(NB), .CMD_WIDTH(CW), .STS_WIDTH(SW), .TAG_DEPTH(TD)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus.slave),
        .busy   (busy)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_idle();
        bus.s_cmd_tvalid = '0;
        bus.s_cmd_tdata  = '0;
        bus.s_cpl_tready = '0;
        bus.s_sts_tready = '0;
        bus.m_cmd_tready = 1'b0;
        bus.m_cpl_tvalid = 1'b0;
        bus.m_cpl_tdata  = '0;
        bus.m_sts_tvalid = 1'b0;
        bus.m_sts_tdata  = '0;
    endtask

    task automatic apply_reset();
        drive_idle();
        areset = 1'b1;
        step();
        step();
        areset = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        areset = 1'b1;
        step();
        bus.s_cmd_tvalid = 4'hF;
        bus.m_cpl_tvalid = 1'b1;
        bus.m_sts_tvalid = 1'b1;
        bus.s_cpl_tready = 4'hF;
        bus.s_sts_tready = 4'hF;
        #1;
        total++; if (bus.s_cmd_tready !== 4'h0) begin bad++; $display("FAIL rst_s_cmd_tready: got %b want 0000", bus.s_cmd_tready); end
        total++; if (bus.s_cpl_tvalid !== 4'h0) begin bad++; $display("FAIL rst_s_cpl_tvalid: got %b want 0000", bus.s_cpl_tvalid); end
        total++; if (bus.s_sts_tvalid !== 4'h0) begin bad++; $display("FAIL rst_s_sts_tvalid: got %b want 0000", bus.s_sts_tvalid); end
        total++; if (bus.m_cmd_tvalid !== 1'b0) begin bad++; $display("FAIL rst_m_cmd_tvalid: got %b want 0", bus.m_cmd_tvalid); end
        total++; if (bus.m_cmd_tdata !== 128'h0) begin bad++; $display("FAIL rst_m_cmd_tdata: got %h want 0", bus.m_cmd_tdata); end
        total++; if (bus.m_cpl_tready !== 1'b0) begin bad++; $display("FAIL rst_m_cpl_tready: got %b want 0", bus.m_cpl_tready); end
        total++; if (bus.m_sts_tready !== 1'b0) begin bad++; $display("FAIL rst_m_sts_tready: got %b want 0", bus.m_sts_tready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        drive_idle();
        step();
        areset = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        bus.m_cmd_tready = 1'b1;
        bus.s_cpl_tready = 4'hF;
        bus.s_sts_tready = 4'hF;
        bus.s_cmd_tvalid = 4'b0100;
        bus.s_cmd_tdata[2*CW +: CW] = 128'hA5;
        #1;
        total++; if (bus.s_cmd_tready !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", bus.s_cmd_tready); end
        step();
        bus.s_cmd_tvalid = '0;
        #1;
        total++; if (bus.m_cmd_tvalid !== 1'b1) begin bad++; $display("FAIL single_m_valid: got %b want 1", bus.m_cmd_tvalid); end
        total++; if (bus.m_cmd_tdata !== 128'hA5) begin bad++; $display("FAIL single_m_data: got %h want a5", bus.m_cmd_tdata); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_cmd: got %b want 1", busy); end
        step();
        bus.m_cpl_tvalid = 1'b1;
        bus.m_cpl_tdata  = 128'h11;
        #1;
        total++; if (bus.m_cmd_tvalid !== 1'b0) begin bad++; $display("FAIL single_m_drained: got %b want 0", bus.m_cmd_tvalid); end
        total++; if (bus.s_cpl_tvalid !== 4'b0100) begin bad++; $display("FAIL single_cpl_route: got %b want 0100", bus.s_cpl_tvalid); end
        total++; if (bus.s_cpl_tdata[2*CW +: CW] !== 128'h11) begin bad++; $display("FAIL single_cpl_data: got %h want 11", bus.s_cpl_tdata[2*CW +: CW]); end
        total++; if (bus.m_cpl_tready !== 1'b1) begin bad++; $display("FAIL single_cpl_ready: got %b want 1", bus.m_cpl_tready); end
        total++; if (bus.s_sts_tvalid !== 4'b0000) begin bad++; $display("FAIL single_sts_quiet: got %b want 0000", bus.s_sts_tvalid); end
        step();
        bus.m_sts_tvalid = 1'b1;
        bus.m_sts_tdata  = 8'h03;
        #1;
        total++; if (bus.s_sts_tvalid !== 4'b0100) begin bad++; $display("FAIL single_sts_route: got %b want 0100", bus.s_sts_tvalid); end
        total++; if (bus.s_sts_tdata[2*SW +: SW] !== 8'h03) begin bad++; $display("FAIL single_sts_data: got %h want 03", bus.s_sts_tdata[2*SW +: SW]); end
        total++; if (bus.s_cpl_tvalid !== 4'b0000) begin bad++; $display("FAIL single_cpl_done_hold: got %b want 0000", bus.s_cpl_tvalid); end
        total++; if (bus.m_cpl_tready !== 1'b0) begin bad++; $display("FAIL single_cpl_done_ready: got %b want 0", bus.m_cpl_tready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_tag: got %b want 1", busy); end
        step();
        bus.m_sts_tvalid = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
        total++; if (bus.m_cpl_tready !== 1'b0) begin bad++; $display("FAIL single_empty_backpressure: got %b want 0", bus.m_cpl_tready); end
        total++; if (bus.s_cpl_tvalid !== 4'b0000) begin bad++; $display("FAIL single_empty_route: got %b want 0000", bus.s_cpl_tvalid); end
        drive_idle();
    endtask

    task automatic test_rr_order();
        logic [NB-1:0] exp_rdy;
        logic [CW-1:0] exp_data;
        int            exp_ch;
        apply_reset();
        bus.m_cmd_tready = 1'b1;
        for (int c = 0; c < NB; c++) bus.s_cmd_tdata[c*CW +: CW] = CW'(32'h100 + c);
        bus.s_cmd_tvalid = 4'hF;
        for (int k = 0; k < TD; k++) begin
`ifdef BSTER_CMD_MUX_PRIO_EN
            exp_ch = 0;
`else
            exp_ch = k % NB;
`endif
            exp_rdy = '0;
            exp_rdy[exp_ch] = 1'b1;
            #1;
            total++; if (bus.s_cmd_tready !== exp_rdy) begin bad++; $display("FAIL rr_grant_%0d: got %b want %b", k, bus.s_cmd_tready, exp_rdy); end
            step();
            exp_data = CW'(32'h100 + exp_ch);
            total++; if (bus.m_cmd_tdata !== exp_data) begin bad++; $display("FAIL rr_data_%0d: got %h want %h", k, bus.m_cmd_tdata, exp_data); end
        end
        #1;
        total++; if (bus.s_cmd_tready !== 4'b0000) begin bad++; $display("FAIL rr_full_stall: got %b want 0000", bus.s_cmd_tready); end
        drive_idle();
    endtask

    task automatic test_stall();
        apply_reset();
        bus.s_cmd_tvalid = 4'b0011;
        bus.s_cmd_tdata[0*CW +: CW] = 128'hC0;
        bus.s_cmd_tdata[1*CW +: CW] = 128'hC1;
        #1;
        total++; if (bus.s_cmd_tready !== 4'b0001) begin bad++; $display("FAIL stall_first_grant: got %b want 0001", bus.s_cmd_tready); end
        step();
        bus.s_cmd_tvalid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (bus.s_cmd_tready !== 4'b0000) begin bad++; $display("FAIL stall_ready_%0d: got %b want 0000", k, bus.s_cmd_tready); end
            total++; if (bus.m_cmd_tvalid !== 1'b1) begin bad++; $display("FAIL stall_valid_%0d: got %b want 1", k, bus.m_cmd_tvalid); end
            total++; if (bus.m_cmd_tdata !== 128'hC0) begin bad++; $display("FAIL stall_data_%0d: got %h want c0", k, bus.m_cmd_tdata); end
            step();
        end
        bus.m_cmd_tready = 1'b1;
        #1;
        total++; if (bus.s_cmd_tready !== 4'b0010) begin bad++; $display("FAIL stall_resume_grant: got %b want 0010", bus.s_cmd_tready); end
        step();
        bus.s_cmd_tvalid = '0;
        #1;
        total++; if (bus.m_cmd_tdata !== 128'hC1) begin bad++; $display("FAIL stall_resume_data: got %h want c1", bus.m_cmd_tdata); end
        drive_idle();
    endtask

    task automatic test_full();
        apply_reset();
        bus.m_cmd_tready = 1'b1;
        bus.s_cmd_tvalid = 4'b0001;
        for (int k = 0; k < TD; k++) begin
            bus.s_cmd_tdata[0*CW +: CW] = CW'(k + 1);
            step();
        end
        bus.s_cmd_tdata[0*CW +: CW] = 128'h9;
        step();
        #1;
        total++; if (bus.s_cmd_tready !== 4'b0000) begin bad++; $display("FAIL full_ninth_stall: got %b want 0000", bus.s_cmd_tready); end
        total++; if (bus.m_cmd_tvalid !== 1'b0) begin bad++; $display("FAIL full_reg_empty: got %b want 0", bus.m_cmd_tvalid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL full_busy: got %b want 1", busy); end
        step();
        bus.m_cpl_tvalid = 1'b1;
        bus.m_sts_tvalid = 1'b1;
        bus.s_cpl_tready = 4'hF;
        bus.s_sts_tready = 4'hF;
        #1;
        total++; if (bus.s_cpl_tvalid !== 4'b0001) begin bad++; $display("FAIL full_pop_route: got %b want 0001", bus.s_cpl_tvalid); end
        total++; if (bus.s_cmd_tready !== 4'b0001) begin bad++; $display("FAIL full_accept_on_pop: got %b want 0001", bus.s_cmd_tready); end
        step();
        bus.m_cpl_tvalid = 1'b0;
        bus.m_sts_tvalid = 1'b0;
        #1;
        total++; if (bus.m_cmd_tdata !== 128'h9) begin bad++; $display("FAIL full_ninth_data: got %h want 9", bus.m_cmd_tdata); end
        total++; if (bus.s_cmd_tready !== 4'b0000) begin bad++; $display("FAIL full_still_full: got %b want 0000", bus.s_cmd_tready); end
        drive_idle();
    endtask

    task automatic test_sts_first();
        apply_reset();
        bus.m_cmd_tready = 1'b1;
        bus.s_cmd_tvalid = 4'b0010;
        step();
        bus.s_cmd_tvalid = 4'b1000;
        #1;
        total++; if (bus.s_cmd_tready !== 4'b1000) begin bad++; $display("FAIL sf_second_grant: got %b want 1000", bus.s_cmd_tready); end
        step();
        bus.s_cmd_tvalid = '0;
        bus.m_sts_tvalid = 1'b1;
        bus.m_sts_tdata  = 8'h51;
        bus.m_cpl_tvalid = 1'b1;
        bus.m_cpl_tdata  = 128'h77;
        bus.s_sts_tready = 4'hF;
        bus.s_cpl_tready = 4'h0;
        #1;
        total++; if (bus.s_sts_tvalid !== 4'b0010) begin bad++; $display("FAIL sf_sts_route: got %b want 0010", bus.s_sts_tvalid); end
        total++; if (bus.m_sts_tready !== 1'b1) begin bad++; $display("FAIL sf_sts_ready: got %b want 1", bus.m_sts_tready); end
        total++; if (bus.s_cpl_tvalid !== 4'b0010) begin bad++; $display("FAIL sf_cpl_offer: got %b want 0010", bus.s_cpl_tvalid); end
        total++; if (bus.m_cpl_tready !== 1'b0) begin bad++; $display("FAIL sf_cpl_held: got %b want 0", bus.m_cpl_tready); end
        step();
        bus.m_sts_tdata = 8'h53;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (bus.s_sts_tvalid !== 4'b0000) begin bad++; $display("FAIL sf_next_sts_blocked_%0d: got %b want 0000", k, bus.s_sts_tvalid); end
            total++; if (bus.m_sts_tready !== 1'b0) begin bad++; $display("FAIL sf_next_sts_ready_%0d: got %b want 0", k, bus.m_sts_tready); end
            total++; if (bus.s_cpl_tvalid !== 4'b0010) begin bad++; $display("FAIL sf_cpl_wait_%0d: got %b want 0010", k, bus.s_cpl_tvalid); end
            step();
        end
        bus.s_cpl_tready = 4'hF;
        #1;
        total++; if (bus.m_cpl_tready !== 1'b1) begin bad++; $display("FAIL sf_cpl_release: got %b want 1", bus.m_cpl_tready); end
        total++; if (bus.s_sts_tvalid !== 4'b0000) begin bad++; $display("FAIL sf_sts_still_blocked: got %b want 0000", bus.s_sts_tvalid); end
        step();
        bus.m_cpl_tdata = 128'h78;
        #1;
        total++; if (bus.s_sts_tvalid !== 4'b1000) begin bad++; $display("FAIL sf_ch3_sts: got %b want 1000", bus.s_sts_tvalid); end
        total++; if (bus.s_sts_tdata[3*SW +: SW] !== 8'h53) begin bad++; $display("FAIL sf_ch3_sts_data: got %h want 53", bus.s_sts_tdata[3*SW +: SW]); end
        total++; if (bus.s_cpl_tvalid !== 4'b1000) begin bad++; $display("FAIL sf_ch3_cpl: got %b want 1000", bus.s_cpl_tvalid); end
        total++; if (bus.s_cpl_tdata[3*CW +: CW] !== 128'h78) begin bad++; $display("FAIL sf_ch3_cpl_data: got %h want 78", bus.s_cpl_tdata[3*CW +: CW]); end
        step();
        bus.m_cpl_tvalid = 1'b0;
        bus.m_sts_tvalid = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sf_busy_end: got %b want 0", busy); end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.m_cmd_tready = 1'b1;
        bus.s_cmd_tvalid = 4'b0111;
        step();
        step();
        step();
        bus.m_cmd_tready = 1'b0;
        bus.m_cpl_tvalid = 1'b1;
        bus.m_sts_tvalid = 1'b1;
        bus.s_cpl_tready = 4'hF;
        bus.s_sts_tready = 4'hF;
        #1;
        total++; if (bus.m_cmd_tvalid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", bus.m_cmd_tvalid); end
        total++; if (bus.s_cpl_tvalid !== 4'b0001) begin bad++; $display("FAIL mid_pre_route: got %b want 0001", bus.s_cpl_tvalid); end
        areset = 1'b1;
        #1;
        total++; if (bus.m_cmd_tvalid !== 1'b0) begin bad++; $display("FAIL mid_m_valid: got %b want 0", bus.m_cmd_tvalid); end
        total++; if (bus.s_cmd_tready !== 4'b0000) begin bad++; $display("FAIL mid_s_ready: got %b want 0000", bus.s_cmd_tready); end
        total++; if (bus.s_cpl_tvalid !== 4'b0000) begin bad++; $display("FAIL mid_cpl_valid: got %b want 0000", bus.s_cpl_tvalid); end
        total++; if (bus.s_sts_tvalid !== 4'b0000) begin bad++; $display("FAIL mid_sts_valid: got %b want 0000", bus.s_sts_tvalid); end
        total++; if (bus.m_cpl_tready !== 1'b0) begin bad++; $display("FAIL mid_cpl_ready: got %b want 0", bus.m_cpl_tready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        step();
        drive_idle();
        step();
        areset = 1'b0;
        bus.m_cmd_tready = 1'b1;
        bus.s_cpl_tready = 4'hF;
        bus.s_sts_tready = 4'hF;
        bus.s_cmd_tvalid = 4'b1000;
        bus.s_cmd_tdata[3*CW +: CW] = 128'hD3;
        #1;
        total++; if (bus.s_cmd_tready !== 4'b1000) begin bad++; $display("FAIL mid_new_grant: got %b want 1000", bus.s_cmd_tready); end
        step();
        bus.s_cmd_tvalid = '0;
        #1;
        total++; if (bus.m_cmd_tdata !== 128'hD3) begin bad++; $display("FAIL mid_new_data: got %h want d3", bus.m_cmd_tdata); end
        step();
        bus.m_cpl_tvalid = 1'b1;
        bus.m_sts_tvalid = 1'b1;
        #1;
        total++; if (bus.s_cpl_tvalid !== 4'b1000) begin bad++; $display("FAIL mid_new_cpl_route: got %b want 1000", bus.s_cpl_tvalid); end
        total++; if (bus.s_sts_tvalid !== 4'b1000) begin bad++; $display("FAIL mid_new_sts_route: got %b want 1000", bus.s_sts_tvalid); end
        step();
        drive_idle();
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_end: got %b want 0", busy); end
    endtask

    initial begin
        drive_idle();
        areset = 1'b1;
        test_reset();
        test_single();
        test_rr_order();
        test_stall();
        test_full();
        test_sts_first();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
